// File: rtl/alu_exec_stage_if.sv
// Handshake bus of the ALU execute stage: an operation channel going in
// and a result channel coming out, each with its own valid/ready pair.
interface alu_exec_stage_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_alu_control;
    logic [WIDTH-1:0] in_src_a;
    logic [WIDTH-1:0] in_src_b;
    logic [TAGW-1:0]  in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_illegal;
    logic [TAGW-1:0]  out_tag;

    // The execute stage itself.
    modport slave (
        input  in_valid, in_alu_control, in_src_a, in_src_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_illegal, out_tag
    );

    // The surrounding pipeline: operand fetch upstream, writeback downstream.
    modport master (
        output in_valid, in_alu_control, in_src_a, in_src_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_illegal, out_tag
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage. The result is computed when an operation is
// accepted, then held in a two-entry buffer made of a head register, which
// drives the outputs, and a skid register that absorbs one extra operation
// while the consumer stalls. in_ready is registered from the occupancy
// alone, so out_ready never reaches in_ready combinationally.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input logic               clk,
    input logic               reset,
    alu_exec_stage_if.slave   bus
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             ready_q;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] new_result;
    logic             new_illegal;
    logic             slt_bit;

    logic [WIDTH-1:0] head_result;
    logic             head_illegal;
    logic [TAGW-1:0]  head_tag;
    logic [WIDTH-1:0] skid_result;
    logic             skid_illegal;
    logic [TAGW-1:0]  skid_tag;

    assign push = bus.in_valid && ready_q;
    assign pop  = (state != EMPTY) && bus.out_ready;

    // A signed compare of the operands themselves, so an overflowing A - B
    // cannot flip the answer.
    assign slt_bit = $signed(bus.in_src_a) < $signed(bus.in_src_b);

    // Evaluate the incoming operation; only captured into storage on a push.
    always_comb begin
        new_result  = '0;
        new_illegal = 1'b0;
        case (bus.in_alu_control)
            3'b000:  new_result = bus.in_src_a + bus.in_src_b;
            3'b001:  new_result = bus.in_src_a + ~bus.in_src_b + WIDTH'(1);
            3'b010:  new_result = bus.in_src_a & bus.in_src_b;
            3'b011:  new_result = bus.in_src_a | bus.in_src_b;
            3'b101:  new_result = {{(WIDTH-1){1'b0}}, slt_bit};
            default: new_illegal = 1'b1;
        endcase
    end

    // Occupancy transitions; FULL only ever drains because in_ready is low there.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (pop && !push) state_next = EMPTY;
            end
            FULL:  if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Occupancy register and the registered ready derived from the next occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != FULL);
        end
    end

    // Head and skid storage; the head changes only when it is free or popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_result  <= '0;
            head_illegal <= 1'b0;
            head_tag     <= '0;
            skid_result  <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else begin
            if ((state == EMPTY && push) || (state == ONE && push && pop)) begin
                head_result  <= new_result;
                head_illegal <= new_illegal;
                head_tag     <= bus.in_tag;
            end else if (state == FULL && pop) begin
                head_result  <= skid_result;
                head_illegal <= skid_illegal;
                head_tag     <= skid_tag;
            end
            if (state == ONE && push && !pop) begin
                skid_result  <= new_result;
                skid_illegal <= new_illegal;
                skid_tag     <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = (state != EMPTY);
    assign bus.out_result  = head_result;
    assign bus.out_zero    = (state != EMPTY) && (head_result == '0);
    assign bus.out_illegal = head_illegal;
    assign bus.out_tag     = head_tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: a queue-based reference model
// checked every cycle, plus directed cases with literal expected values.
module tb_alu_exec_stage;

    localparam int WIDTH = 32;
    localparam int TAGW  = 5;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             illegal;
        logic [TAGW-1:0]  tag;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    bit     checking_on = 1'b0;
    int     n_checks = 0;
    int     n_pass = 0;
    entry_t model_q[$];
    logic   model_ready = 1'b0;

    alu_exec_stage_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus();

    alu_exec_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // What the stage must report for one operation, from the opcode table.
    function automatic entry_t model_op(input logic [2:0] code, input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
        entry_t e;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.illegal = 1'b0;
        e.tag = tag;
        case (code)
            3'd0:    e.result = WIDTH'(longint'(a) + longint'(b));
            3'd1:    e.result = WIDTH'(longint'(a) - longint'(b));
            3'd2:    e.result = a & b;
            3'd3:    e.result = a | b;
            3'd5:    e.result = (sa < sb) ? WIDTH'(1) : '0;
            default: begin e.result = '0; e.illegal = 1'b1; end
        endcase
        e.zero = (e.result == 0);
        return e;
    endfunction

    // Reference model: a FIFO of at most two finished results.
    always @(posedge clk or posedge reset) begin
        bit do_push;
        bit do_pop;
        if (reset) begin
            model_q.delete();
            model_ready = 1'b0;
        end else begin
            do_push = bus.in_valid && model_ready;
            do_pop  = (model_q.size() > 0) && bus.out_ready;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(model_op(bus.in_alu_control, bus.in_src_a, bus.in_src_b, bus.in_tag));
            model_ready = (model_q.size() < 2);
        end
    end

    // Every cycle, compare the DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (checking_on) begin
            check("in_ready", 64'(bus.in_ready), 64'(model_ready));
            check("out_valid", 64'(bus.out_valid), 64'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                check("out_result", 64'(bus.out_result), 64'(model_q[0].result));
                check("out_zero", 64'(bus.out_zero), 64'(model_q[0].zero));
                check("out_illegal", 64'(bus.out_illegal), 64'(model_q[0].illegal));
                check("out_tag", 64'(bus.out_tag), 64'(model_q[0].tag));
            end
        end
    end

    // Offer one op at a negedge and return at the negedge after it is accepted.
    task automatic applyStimulus(input logic [2:0] code, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_alu_control = code;
        bus.in_src_a = a;
        bus.in_src_b = b;
        bus.in_tag = tag;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'(0), 64'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_src_a = 'x;
        bus.in_src_b = 'x;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] result, input logic zero,
                               input logic illegal, input logic [TAGW-1:0] tag);
        check({name, ".valid"}, 64'(bus.out_valid), 64'(1));
        check({name, ".result"}, 64'(bus.out_result), 64'(result));
        check({name, ".zero"}, 64'(bus.out_zero), 64'(zero));
        check({name, ".illegal"}, 64'(bus.out_illegal), 64'(illegal));
        check({name, ".tag"}, 64'(bus.out_tag), 64'(tag));
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return WIDTH'($urandom_range(0, 4));
            default: return $urandom;
        endcase
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        bus.in_valid = 1'b0;
        bus.in_alu_control = 3'd0;
        bus.in_src_a = '0;
        bus.in_src_b = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        checking_on = 1'b1;
        check("rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("rst.out_result", 64'(bus.out_result), 64'(0));
        check("rst.out_zero", 64'(bus.out_zero), 64'(0));
        check("rst.out_illegal", 64'(bus.out_illegal), 64'(0));
        check("rst.out_tag", 64'(bus.out_tag), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.in_ready_after_release", 64'(bus.in_ready), 64'(1));

        // Directed operations with the consumer always ready.
        bus.out_ready = 1'b1;
        applyStimulus(3'b000, 32'd5, 32'd7, 5'd3);
        checkOutput("add", 32'd12, 1'b0, 1'b0, 5'd3);
        applyStimulus(3'b001, 32'd5, 32'd5, 5'd4);
        checkOutput("sub", 32'd0, 1'b1, 1'b0, 5'd4);
        applyStimulus(3'b010, 32'hF0F0, 32'h0FF0, 5'd5);
        checkOutput("and", 32'h00F0, 1'b0, 1'b0, 5'd5);
        applyStimulus(3'b011, 32'hF000, 32'h000F, 5'd6);
        checkOutput("or", 32'hF00F, 1'b0, 1'b0, 5'd6);
        applyStimulus(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd7);
        checkOutput("slt_neg1_1", 32'd1, 1'b0, 1'b0, 5'd7);
        applyStimulus(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 5'd8);
        checkOutput("slt_max_min", 32'd0, 1'b1, 1'b0, 5'd8);
        applyStimulus(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 5'd9);
        checkOutput("slt_min_max", 32'd1, 1'b0, 1'b0, 5'd9);
        applyStimulus(3'b101, 32'd3, 32'd3, 5'd10);
        checkOutput("slt_equal", 32'd0, 1'b1, 1'b0, 5'd10);
        applyStimulus(3'b100, 32'd9, 32'd9, 5'd11);
        checkOutput("illegal100", 32'd0, 1'b1, 1'b1, 5'd11);
        applyStimulus(3'b110, 32'd9, 32'd9, 5'd12);
        checkOutput("illegal110", 32'd0, 1'b1, 1'b1, 5'd12);
        applyStimulus(3'b111, 32'd9, 32'd9, 5'd13);
        checkOutput("illegal111", 32'd0, 1'b1, 1'b1, 5'd13);
        applyStimulus(3'b000, 32'd1, 32'd2, 5'd14);
        checkOutput("add_after_illegal", 32'd3, 1'b0, 1'b0, 5'd14);
        @(negedge clk);

        // Backpressure: tags 1 and 2 fill the buffer, tag 3 stalls.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_alu_control = 3'b000;
        bus.in_src_a = 32'd100;
        bus.in_src_b = 32'd1;
        bus.in_tag = 5'd1;
        @(negedge clk);
        check("bp.ready_after_1", 64'(bus.in_ready), 64'(1));
        bus.in_tag = 5'd2;
        @(negedge clk);
        check("bp.ready_after_2", 64'(bus.in_ready), 64'(0));
        check("bp.head_is_1", 64'(bus.out_tag), 64'(1));
        bus.in_tag = 5'd3;
        @(negedge clk);
        check("bp.stall_ready", 64'(bus.in_ready), 64'(0));
        check("bp.stall_head", 64'(bus.out_tag), 64'(1));
        check("bp.stall_result", 64'(bus.out_result), 64'(101));
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp.drain_2", 64'(bus.out_tag), 64'(2));
        check("bp.ready_again", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        check("bp.drain_3", 64'(bus.out_tag), 64'(3));
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp.empty", 64'(bus.out_valid), 64'(0));

        // Push and pop together at count one for 20 cycles.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            bus.in_valid = 1'b1;
            bus.in_alu_control = 3'($urandom_range(0, 7));
            bus.in_src_a = rand_operand();
            bus.in_src_b = rand_operand();
            bus.in_tag = TAGW'($urandom);
            @(negedge clk);
            check("stream.in_ready", 64'(bus.in_ready), 64'(1));
            check("stream.out_valid", 64'(bus.out_valid), 64'(1));
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_alu_control = 3'($urandom_range(0, 7));
            bus.in_tag = TAGW'($urandom);
            if (bus.in_valid) begin
                bus.in_src_a = rand_operand();
                bus.in_src_b = rand_operand();
            end else begin
                bus.in_src_a = 'x;
                bus.in_src_b = 'x;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset while full, asserted in the middle of a clock period.
        bus.out_ready = 1'b0;
        applyStimulus(3'b000, 32'd20, 32'd1, 5'd21);
        applyStimulus(3'b000, 32'd30, 32'd1, 5'd22);
        check("rst_mid.full", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid.out_valid_async", 64'(bus.out_valid), 64'(0));
        check("rst_mid.in_ready_async", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid.in_ready_after", 64'(bus.in_ready), 64'(1));
        check("rst_mid.no_stale", 64'(bus.out_valid), 64'(0));
        repeat (3) @(negedge clk);
        check("rst_mid.still_empty", 64'(bus.out_valid), 64'(0));

        checking_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage that consumes the 3-bit ALUControl code produced by the ALU decoder, together with two operands.
- Computes the result and flags, and delivers them through a 2-entry output buffer using a valid/ready handshake.
- Sits between the decode/operand-fetch logic and writeback/branch logic in the pipelined core.
- Absorbs downstream backpressure without dropping or duplicating operations.

Parameters:
- WIDTH, 32, operand and result width in bits (≥ 2).
- TAGW, 5, width of the opaque tag that travels with each operation (destination register index).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation present on the in_* bus
- in_ready  output  1  stage can accept an operation this cycle
- in_alu_control  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt; all other codes are illegal
- in_src_a  input  WIDTH  operand A
- in_src_b  input  WIDTH  operand B
- in_tag  input  TAGW  opaque tag, returned unchanged
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts the head entry
- out_result  output  WIDTH  result of the head entry
- out_zero  output  1  head entry result == 0
- out_illegal  output  1  head entry carried an illegal code
- out_tag  output  TAGW  tag of the head entry

Behaviour:
- Reset (asynchronous assert, synchronous release): buffer empty, count = 0.
  - out_valid = 0, out_result = 0, out_zero = 0, out_illegal = 0, out_tag = 0.
  - in_ready = 1 from the first clock edge after release.
- Accept rule: push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < 2). It is a registered function of count only; it does not depend on out_ready in the same cycle, so there is no combinational path from out_ready to in_ready.
- Latency: an op pushed at edge N is visible on out_* after edge N when the buffer was empty. Otherwise it appears once all older entries have popped. Order is strictly FIFO.
- Arithmetic, computed at push time and stored:
  - add: A + B modulo 2^WIDTH.
  - sub: A − B modulo 2^WIDTH (A + ~B + 1).
  - and: A & B. or: A | B.
  - slt: signed compare. Result = {WIDTH-1 zeros, 1} if A < B (two's complement), else 0. The correct answer is required even when A − B overflows.
  - Illegal code: result = 0, zero = 1, illegal = 1.
- zero is recomputed from the stored result; it is never taken from the inputs.
- Count state: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push → ONE. A pop cannot occur.
  - ONE, push only → FULL; pop only → EMPTY; push and pop together → stays ONE, the head is replaced by the new op the same edge.
  - FULL: in_ready = 0, so only a pop can occur → ONE, and the second entry becomes the head.
- Storage is a head register plus a skid register.
  - out_* are driven directly from the head register; no combinational path from in_* to out_*.
- Stability: while out_valid && !out_ready, all out_* hold stable.
- When in_ready = 0, in_* values are ignored.
- Reset mid-operation discards all buffered entries. No partial output is produced after reset.
- X on in_* while in_valid = 0 must not propagate to out_*.

Test Plan:
- Directed ops with out_ready = 1:
  - add 5 + 7 → 12, zero = 0.
  - sub 5 − 5 → 0, zero = 1.
  - and 0xF0F0 & 0x0FF0 → 0x00F0.
  - or 0xF000 | 0x000F → 0xF00F.
  - Each appears exactly one cycle after acceptance, with the matching tag.
- slt signed edges:
  - A = 0xFFFFFFFF, B = 1 → 1.
  - A = 0x7FFFFFFF, B = 0x80000000 → 0.
  - A = 0x80000000, B = 0x7FFFFFFF → 1.
  - A = B = 3 → 0, zero = 1.
- Illegal codes 100, 110, 111: result = 0, zero = 1, illegal = 1, tag preserved. A following legal add reports illegal = 0.
- Backpressure: hold out_ready = 0 and offer tags 1, 2, 3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready drops after the second push; tag 3 stalls with out_* held at tag 1.
  - Release out_ready: outputs are 1, 2, 3 in order, with no duplicates or losses.
- Simultaneous push and pop at count = 1 for 20 cycles with random ops: one result per cycle, in_ready stays 1, and results match the reference model.
- Assert reset while count = 2 and mid-clock: out_valid drops immediately (asynchronous). After release, count = 0, in_ready = 1, and no stale result appears.
